// File: rtl/fence_seq_pkg.sv
// Shared types for the fence sequencer: request kinds, FSM states and the perf counter width.
package fence_seq_pkg;

    typedef enum logic [1:0] {
        FENCE      = 2'b00,
        FENCE_I    = 2'b01,
        SFENCE_VMA = 2'b10,
        RSVD       = 2'b11
    } fence_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StWalk,
        StIcInv,
        StTlbFl,
        StDone
    } fence_state_e;

    localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/fence_seq_walker.sv
// D$ set/way walk counter: way is the fast index, the set advances when the way wraps.
module fence_seq_walker #(
    parameter int unsigned NR_SETS = 128,
    parameter int unsigned NR_WAYS = 2,
    parameter int unsigned SET_W   = $clog2(NR_SETS),
    parameter int unsigned WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [SET_W-1:0] set_o,
    output logic [WAY_W-1:0] way_o,
    output logic             last_o
);

    localparam logic [SET_W-1:0] SetLast = SET_W'(NR_SETS - 1);
    localparam logic [WAY_W-1:0] WayLast = WAY_W'(NR_WAYS - 1);

    logic [SET_W-1:0] r_set;
    logic [SET_W-1:0] w_set_next;
    logic [WAY_W-1:0] r_way;
    logic [WAY_W-1:0] w_way_next;
    logic             w_way_wrap;

    assign w_way_wrap = (r_way == WayLast);

    // Power-of-two set count lets the final increment wrap the set back to 0.
    always_comb begin
        w_set_next = r_set;
        w_way_next = r_way;
        if (clr_i) begin
            w_set_next = '0;
            w_way_next = '0;
        end else if (adv_i) begin
            if (w_way_wrap) begin
                w_way_next = '0;
                w_set_next = r_set + 1'b1;
            end else begin
                w_way_next = r_way + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_set <= '0;
            r_way <= '0;
        end else begin
            r_set <= w_set_next;
            r_way <= w_way_next;
        end
    end

    assign set_o  = r_set;
    assign way_o  = r_way;
    assign last_o = (r_set == SetLast) && w_way_wrap;

endmodule

// File: rtl/fence_sequencer.sv
// Sequences write-buffer drain, D$ clean+invalidate walk, I$ invalidate and TLB flush for fences.
// Optional CVA6_FENCE_SEQ_PERF_EN adds perf_cycles_o, the latency of the last completed sequence.
module fence_sequencer
    import fence_seq_pkg::*;
#(
    parameter int unsigned NR_SETS = 128,
    parameter int unsigned NR_WAYS = 2,
    parameter int unsigned SET_W   = $clog2(NR_SETS),
    parameter int unsigned WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [1:0]        req_type_i,
    output logic              req_ready_o,
    output logic              busy_o,
    output logic              done_o,
    input  logic              wbuf_empty_i,
    output logic              dc_flush_valid_o,
    input  logic              dc_flush_ready_i,
    output logic [SET_W-1:0]  dc_flush_set_o,
    output logic [WAY_W-1:0]  dc_flush_way_o,
    output logic              ic_flush_o,
`ifdef CVA6_FENCE_SEQ_PERF_EN
    output logic [PERF_W-1:0] perf_cycles_o,
`endif
    output logic              tlb_flush_o
);

    fence_state_e r_state;
    fence_state_e w_state_next;
    fence_type_e  r_type;
    logic         w_accept;
    logic         w_walk_hs;
    logic         w_last;

    assign w_accept  = (r_state == StIdle) && req_valid_i;
    assign w_walk_hs = (r_state == StWalk) && dc_flush_ready_i;

    fence_seq_walker #(
        .NR_SETS (NR_SETS),
        .NR_WAYS (NR_WAYS),
        .SET_W   (SET_W),
        .WAY_W   (WAY_W)
    ) u_walker (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_accept),
        .adv_i  (w_walk_hs),
        .set_o  (dc_flush_set_o),
        .way_o  (dc_flush_way_o),
        .last_o (w_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_type  <= FENCE;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_type <= fence_type_e'(req_type_i);
            end
        end
    end

    // Reserved requests fall through every type test and behave as FENCE.
    always_comb begin
        w_state_next     = r_state;
        req_ready_o      = 1'b0;
        busy_o           = 1'b1;
        done_o           = 1'b0;
        dc_flush_valid_o = 1'b0;
        ic_flush_o       = 1'b0;
        tlb_flush_o      = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (wbuf_empty_i) begin
                    w_state_next = (r_type == SFENCE_VMA) ? StTlbFl : StWalk;
                end
            end
            StWalk: begin
                dc_flush_valid_o = 1'b1;
                if (dc_flush_ready_i && w_last) begin
                    w_state_next = (r_type == FENCE_I) ? StIcInv : StDone;
                end
            end
            StIcInv: begin
                ic_flush_o   = 1'b1;
                w_state_next = StDone;
            end
            StTlbFl: begin
                tlb_flush_o  = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                done_o       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

`ifdef CVA6_FENCE_SEQ_PERF_EN
    logic [PERF_W-1:0] r_perf_run;
    logic [PERF_W-1:0] r_perf_last;
    logic [PERF_W-1:0] w_perf_inc;

    assign w_perf_inc = (r_perf_run == '1) ? r_perf_run : r_perf_run + 1'b1;

    // r_perf_run counts busy cycles already elapsed; the DONE cycle itself is added on capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_run  <= '0;
            r_perf_last <= '0;
        end else begin
            if (w_accept) begin
                r_perf_run <= '0;
            end else if (r_state != StIdle) begin
                r_perf_run <= w_perf_inc;
            end
            if (r_state == StDone) begin
                r_perf_last <= w_perf_inc;
            end
        end
    end

    assign perf_cycles_o = r_perf_last;
`endif

endmodule

// File: tb/tb_fence_sequencer.sv
// Self-checking bench for fence_sequencer: directed vector table, corner sequences, random run.
module tb_fence_sequencer;

    localparam int NS = 128;
    localparam int NW = 2;
    localparam int NR = 4000;
    localparam logic [13:0] RST_VEC = 14'b10_0000_0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_type = 2'b00;
    logic       wbuf = 1'b0;
    logic       dc_ready = 1'b0;
    logic       req_ready, busy, done, dcv, ic, tlb;
    logic [6:0] set;
    logic [0:0] way;
`ifdef CVA6_FENCE_SEQ_PERF_EN
    logic [15:0] perf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fence_sequencer #(
        .NR_SETS (NS),
        .NR_WAYS (NW)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_type_i       (req_type),
        .req_ready_o      (req_ready),
        .busy_o           (busy),
        .done_o           (done),
        .wbuf_empty_i     (wbuf),
        .dc_flush_valid_o (dcv),
        .dc_flush_ready_i (dc_ready),
        .dc_flush_set_o   (set),
        .dc_flush_way_o   (way),
        .ic_flush_o       (ic),
`ifdef CVA6_FENCE_SEQ_PERF_EN
        .perf_cycles_o    (perf),
`endif
        .tlb_flush_o      (tlb)
    );

    typedef struct {
        logic [1:0] ty;
        int         dly;
        bit         tog;
        int         exp_done;
        int         exp_hs;
        int         exp_ic_at;
        int         exp_tlb_at;
    } vec_t;

    typedef struct {
        bit rdy, bsy, dn, v, icf, tlbf;
        int st, wy;
    } cyc_t;

    vec_t vecs[7];
    bit   rv[NR], rw[NR], rr[NR];
    logic [1:0] rt[NR];
    cyc_t obs[NR], expc[NR];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [13:0] outv();
        return {req_ready, busy, done, dcv, ic, tlb, set, way};
    endfunction

    function automatic int fld(input cyc_t x, input int i);
        case (i)
            0: return int'(x.rdy);
            1: return int'(x.bsy);
            2: return int'(x.dn);
            3: return int'(x.v);
            4: return int'(x.icf);
            5: return int'(x.tlbf);
            6: return x.st;
            default: return x.wy;
        endcase
    endfunction

    // Issues one request from IDLE; wbuf low for the first dly cycles after accept, ready low up
    // to cycle hold and optionally only on even cycles. Returns to the caller back in IDLE.
    task automatic run_txn(input logic [1:0] ty, input int dly, input bit tog, input int hold,
                           input int budget, output int done_at, output int hs_n,
                           output int ic_n, output int tlb_n, output int err_n,
                           output int ic_at, output int tlb_at);
        int c = 0;
        bit held = 1'b0;
        logic [6:0] hset = '0;
        logic [0:0] hway = '0;
        done_at = -1; hs_n = 0; ic_n = 0; tlb_n = 0; err_n = 0; ic_at = -1; tlb_at = -1;
        req_type = ty;
        while (done_at < 0 && c < budget) begin
            req_valid = (c == 0);
            wbuf      = (c > dly);
            dc_ready  = (c > hold) && (!tog || (c % 2 == 0));
            if (c == 0 && !req_ready) err_n++;
            if (held && (!dcv || set != hset || way != hway)) err_n++;
            held = 1'b0;
            if (dcv) begin
                if (int'(set) != hs_n / NW || int'(way) != hs_n % NW) err_n++;
                if (dc_ready) hs_n++;
                else begin
                    held = 1'b1;
                    hset = set;
                    hway = way;
                end
            end
            if (ic) begin
                ic_n++;
                if (ic_at < 0) ic_at = c;
            end
            if (tlb) begin
                tlb_n++;
                if (tlb_at < 0) tlb_at = c;
            end
            if (done) done_at = c;
            @(posedge clk); #1;
            c++;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int d, hs, icn, tlbn, er, ica, tlba;
        int acc1, acc2, busy_err, done_at, dcv_cnt;
        bit found;

        vecs[0] = '{2'd0, 0,  1'b0, 258, 256, -1,  -1};
        vecs[1] = '{2'd1, 10, 1'b1, 524, 256, 523, -1};
        vecs[2] = '{2'd2, 0,  1'b0, 3,   0,   -1,  2};
        vecs[3] = '{2'd3, 0,  1'b0, 258, 256, -1,  -1};
        vecs[4] = '{2'd2, 3,  1'b0, 6,   0,   -1,  5};
        vecs[5] = '{2'd0, 2,  1'b1, 515, 256, -1,  -1};
        vecs[6] = '{2'd1, 0,  1'b0, 259, 256, 258, -1};

        // Reset values, both while held and right after release.
        #12;
        check("reset_outputs_held", int'(outv()), int'(RST_VEC));
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs_idle", int'(outv()), int'(RST_VEC));

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].ty, vecs[i].dly, vecs[i].tog, 0, 3000, d, hs, icn, tlbn, er, ica,
                    tlba);
            check($sformatf("vec%0d_done_cycle", i), d, vecs[i].exp_done);
            check($sformatf("vec%0d_handshakes", i), hs, vecs[i].exp_hs);
            check($sformatf("vec%0d_ic_cycle", i), ica, vecs[i].exp_ic_at);
            check($sformatf("vec%0d_tlb_cycle", i), tlba, vecs[i].exp_tlb_at);
            check($sformatf("vec%0d_ic_pulses", i), icn, (vecs[i].exp_ic_at >= 0) ? 1 : 0);
            check($sformatf("vec%0d_tlb_pulses", i), tlbn, (vecs[i].exp_tlb_at >= 0) ? 1 : 0);
            check($sformatf("vec%0d_order_stability", i), er, 0);
        end

        // Reserved type with valid held: second accept only after the first completes.
        req_valid = 1'b1; req_type = 2'b11; wbuf = 1'b1; dc_ready = 1'b1;
        acc1 = -1; acc2 = -1; busy_err = 0; done_at = -1;
        for (int c = 0; c <= 260; c++) begin
            if (req_ready) begin
                if (acc1 < 0) acc1 = c;
                else if (acc2 < 0) acc2 = c;
            end
            if (done && done_at < 0) done_at = c;
            if (busy !== ((c == 0 || c == 259) ? 1'b0 : 1'b1)) busy_err++;
            if (ic || tlb) busy_err++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("held_first_accept", acc1, 0);
        check("held_second_accept", acc2, 259);
        check("held_first_done", done_at, 258);
        check("held_busy_profile", busy_err, 0);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("held_second_done_seen", int'(found), 1);
        @(posedge clk); #1;

        // Random traffic compared cycle by cycle against a timeline model.
        for (int i = 0; i < NR; i++) begin
            rv[i] = ($urandom_range(0, 1) == 1);
            rt[i] = 2'($urandom_range(0, 3));
            rw[i] = ($urandom_range(0, 9) < 7);
            rr[i] = ($urandom_range(0, 9) < 6);
        end
        for (int c = 0; c < NR; c++) begin
            req_valid = rv[c]; req_type = rt[c]; wbuf = rw[c]; dc_ready = rr[c];
            obs[c] = '{req_ready, busy, done, dcv, ic, tlb, int'(set), int'(way)};
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int c = 0; c < NR; c++) expc[c] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        begin
            int t = 0;
            while (t < NR) begin
                int c, k;
                logic [1:0] ty;
                if (!rv[t]) begin
                    t++;
                    continue;
                end
                ty = rt[t];
                c  = t + 1;
                while (c < NR && !rw[c]) begin
                    expc[c].rdy = 1'b0; expc[c].bsy = 1'b1;
                    c++;
                end
                if (c < NR) begin expc[c].rdy = 1'b0; expc[c].bsy = 1'b1; end
                c++;
                if (ty == 2'd2) begin
                    if (c < NR) begin expc[c].rdy = 1'b0; expc[c].bsy = 1'b1; expc[c].tlbf = 1'b1; end
                    c++;
                end else begin
                    k = 0;
                    while (c < NR && k < NS * NW) begin
                        expc[c].rdy = 1'b0; expc[c].bsy = 1'b1; expc[c].v = 1'b1;
                        expc[c].st = k / NW; expc[c].wy = k % NW;
                        if (rr[c]) k++;
                        c++;
                    end
                    if (ty == 2'd1) begin
                        if (c < NR) begin expc[c].rdy = 1'b0; expc[c].bsy = 1'b1; expc[c].icf = 1'b1; end
                        c++;
                    end
                end
                if (c < NR) begin expc[c].rdy = 1'b0; expc[c].bsy = 1'b1; expc[c].dn = 1'b1; end
                t = c + 1;
            end
        end
        for (int f = 0; f < 8; f++) begin
            int mm = 0;
            for (int c = 0; c < NR; c++) if (fld(obs[c], f) != fld(expc[c], f)) mm++;
            check($sformatf("random_field%0d_bad_cycles", f), mm, 0);
        end

        // Reset in the middle of a walk, then a clean walk from 0/0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b1; req_type = 2'b00; wbuf = 1'b1; dc_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dcv && set == 7'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("midwalk_reached_set5", int'(found), 1);
        #2 rst = 1'b1;
        #1 check("midwalk_reset_outputs", int'(outv()), int'(RST_VEC));
        @(posedge clk); #1;
        rst = 1'b0;
        dcv_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (dcv) dcv_cnt++;
            @(posedge clk); #1;
        end
        check("midwalk_no_handshakes_after_reset", dcv_cnt, 0);
        run_txn(2'd0, 0, 1'b0, 0, 3000, d, hs, icn, tlbn, er, ica, tlba);
        check("restart_done_cycle", d, 258);
        check("restart_handshakes", hs, 256);
        check("restart_order", er, 0);

`ifdef CVA6_FENCE_SEQ_PERF_EN
        rst = 1'b1;
        @(posedge clk); #1;
        check("perf_reset", int'(perf), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(2'd2, 0, 1'b0, 0, 100, d, hs, icn, tlbn, er, ica, tlba);
        check("perf_sfence", int'(perf), 3);
        run_txn(2'd0, 0, 1'b0, 0, 3000, d, hs, icn, tlbn, er, ica, tlba);
        check("perf_fence", int'(perf), 258);
        run_txn(2'd0, 0, 1'b0, 70000, 71000, d, hs, icn, tlbn, er, ica, tlba);
        check("perf_long_done_cycle", d, 70257);
        check("perf_saturated", int'(perf), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
